// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and state encoding for the instruction fetch unit
package ifu_pkg;
  localparam int IFU_XLEN = 64;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam logic [31:0] IFU_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_STOP  = 2'd3
  } ifu_state_e;
endpackage

// File: rtl/ifu_pc_reg.sv
// pc_reg: program counter register with write enable and async reset to RESET_PC
module pc_reg #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RESET_PC;
    else if (we) q <= d;
endmodule

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch unit with redirect, drop and halt handling
module ifu
  import ifu_pkg::*;
#(
  parameter int XLEN = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt
);
  ifu_state_e state_q, state_d;
  logic drop_q, drop_d, halt_q, run_q, stop_req, redir, fire, take, pc_we;
  logic [31:0] instr_q;
  logic [XLEN-1:0] pc_q, pc_d;
  assign redir = redirect_valid && state_q != S_STOP;
  assign stop_req = halt_q || halt;
  assign instr_valid = state_q == S_HOLD;
  assign fire = instr_valid && instr_ready;
  assign take = state_q == S_WAIT && imem_resp_valid && !drop_q && !redirect_valid;
  // run_q keeps requests off until the first clock after reset release
  assign imem_req_valid = run_q && state_q == S_FETCH && !redirect_valid && !stop_req;
  assign imem_req_addr = pc_q;
  assign pc = pc_q;
  assign instr = instr_q;
  assign pc_we = redir || fire;
  assign pc_d = redir ? {redirect_pc[XLEN-1:2], 2'b00} : pc_q + XLEN'(4);
  pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .we(pc_we), .d(pc_d), .q(pc_q)
  );
  always_comb begin
    state_d = state_q;
    drop_d = drop_q;
    case (state_q)
      S_FETCH: state_d = stop_req ? S_STOP : (imem_req_valid && imem_req_ready) ? S_WAIT : S_FETCH;
      S_WAIT:
        if (imem_resp_valid) begin
          drop_d = 1'b0;
          state_d = (drop_q || redirect_valid) ? (stop_req ? S_STOP : S_FETCH) : S_HOLD;
        end else if (redirect_valid) drop_d = 1'b1;
      S_HOLD: if (redir || fire) state_d = stop_req ? S_STOP : S_FETCH;
      default: state_d = S_STOP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_FETCH;
      drop_q <= 1'b0;
      halt_q <= 1'b0;
      run_q <= 1'b0;
      instr_q <= IFU_NOP;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
      halt_q <= halt_q || halt;
      run_q <= 1'b1;
      if (take) instr_q <= imem_resp_data;
    end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized scoreboard bench for ifu against a transaction-level fetch model
module tb_ifu;
  localparam logic [63:0] RPC = 64'h8000_0000;
  logic clk = 0, rst_n = 0;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, instr_valid, instr_ready;
  logic redirect_valid, halt;
  logic [63:0] imem_req_addr, pc, redirect_pc;
  logic [31:0] imem_resp_data, instr;
  always #5 clk = ~clk;
  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );
  int vecs = 0, errs = 0;
  logic [63:0] exp_aq[$];
  logic [95:0] exp_iq[$];
  logic [63:0] exp_pc = RPC, out_addr = '0;
  bit out = 0, stale = 0;
  int cnt = 0, lat_lo = 0, lat_hi = 0;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    {imem_req_ready, imem_resp_valid, instr_ready, redirect_valid, halt} = '0;
    exp_aq.delete();
    exp_iq.delete();
    exp_pc = RPC;
    out = 0;
    stale = 0;
    #1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  // One clock of stimulus; the memory responds to each accepted request after cnt idle cycles.
  // A fetched word reaches the decoder only if no redirect arrived between request and response.
  task automatic cycle(input bit mr, input bit ir, input bit rd, input logic [63:0] rt,
                       input bit hl, input logic [31:0] d);
    bit r;
    @(negedge clk);
    r = rd && !(instr_valid && !ir);
    imem_req_ready = mr;
    instr_ready = ir;
    redirect_valid = r;
    redirect_pc = rt;
    halt = hl;
    imem_resp_valid = out && cnt == 0;
    imem_resp_data = d;
    #1;
    if (out) chk("one_outstanding", imem_req_valid, 0);
    if (r || hl) chk("req_suppressed", imem_req_valid, 0);
    if (imem_resp_valid) begin
      if (!stale && !r) exp_iq.push_back({out_addr, d});
      out = 0;
    end else if (out) begin
      cnt--;
      if (r) stale = 1;
    end
    if (instr_valid && ir) exp_pc = r ? {rt[63:2], 2'b00} : exp_pc + 64'd4;
    else if (r) exp_pc = {rt[63:2], 2'b00};
    if (imem_req_valid && mr) begin
      exp_aq.push_back(exp_pc);
      out_addr = exp_pc;
      out = 1;
      stale = 0;
      cnt = $urandom_range(lat_hi, lat_lo);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_expected", exp_aq.size() != 0, 1);
        if (exp_aq.size() != 0) chk("req_addr", imem_req_addr, exp_aq.pop_front());
      end
      if (instr_valid && instr_ready) begin
        chk("instr_expected", exp_iq.size() != 0, 1);
        if (exp_iq.size() != 0) chk("instr_pc", {pc, instr}, exp_iq.pop_front());
      end
    end
  end
  initial begin
    logic [31:0] w;
    {imem_req_ready, imem_resp_valid, instr_ready, redirect_valid, halt} = '0;
    imem_resp_data = '0;
    redirect_pc = '0;
    do_reset();
    cycle(1, 1, 0, 0, 0, 0);
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RPC);
    cycle(0, 1, 0, 0, 0, 32'h0010_0093);
    cycle(0, 1, 0, 0, 0, 0);
    chk("first_instr_valid", instr_valid, 1);
    chk("first_instr", {pc, instr}, {RPC, 32'h0010_0093});
    cycle(1, 0, 0, 0, 0, 0);
    chk("second_req_addr", imem_req_addr, RPC + 64'd4);
    w = $urandom;
    cycle(0, 0, 0, 0, 0, w);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, 0, $urandom);
      chk("hold_stable", {instr_valid, imem_req_valid, pc, instr}, {2'b10, RPC + 64'd4, w});
    end
    cycle(0, 1, 0, 0, 0, 0);
    lat_lo = 2;
    lat_hi = 2;
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 64'h8000_0103, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 0, 0, $urandom);
      chk("dropped_no_valid", instr_valid, 0);
    end
    lat_lo = 0;
    lat_hi = 0;
    cycle(1, 1, 0, 0, 0, 0);
    chk("redirect_req", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0100});
    cycle(0, 1, 1, 64'h8000_0200, 0, $urandom);
    cycle(1, 1, 0, 0, 0, 0);
    chk("same_cycle_drop", {instr_valid, imem_req_valid, imem_req_addr}, {2'b01, 64'h8000_0200});
    cycle(0, 1, 0, 0, 0, $urandom);
    cycle(0, 1, 0, 0, 0, 0);
    lat_hi = 2;
    for (int i = 0; i < 3000; i++) begin
      bit ir;
      ir = $urandom_range(0, 3) != 0;
      cycle($urandom_range(0, 2) != 0, ir, $urandom_range(0, 11) == 0, {$urandom, $urandom}, 0, $urandom);
    end
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, $urandom);
    chk("drain_instr", exp_iq.size(), 0);
    chk("drain_req", exp_aq.size(), 0);
    lat_hi = 0;
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, $urandom);
    cycle(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, $urandom_range(0, 1) != 0, {$urandom, $urandom}, 0, 0);
      chk("stop_quiet", {imem_req_valid, instr_valid}, 2'b00);
    end
    do_reset();
    cycle(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("wrap_first", {imem_req_valid, imem_req_addr}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
    cycle(0, 1, 0, 0, 0, $urandom);
    cycle(0, 1, 0, 0, 0, 0);
    lat_lo = 2;
    lat_hi = 2;
    cycle(1, 1, 0, 0, 0, 0);
    chk("wrap_next", {imem_req_valid, imem_req_addr}, {1'b1, 64'h0});
    cycle(0, 1, 0, 0, 0, 0);
    do_reset();
    lat_lo = 0;
    lat_hi = 0;
    cycle(1, 1, 0, 0, 0, 0);
    chk("post_reset_req", {instr_valid, imem_req_valid, imem_req_addr}, {2'b01, RPC});
    cycle(0, 1, 0, 0, 0, $urandom);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
